// File: rtl/signed_seq_divider.sv
// -----------------------------------------------------------------------------
// signed_seq_divider
//
// Sequential signed 16-by-8 integer divider (truncating division).
// Restoring division is performed on the operand magnitudes over 16 CALC
// cycles, followed by a single FIXUP cycle that applies the signs, evaluates
// the overflow / divide-by-zero flags and registers the results.
//
// Handshake: `start` is sampled only in IDLE. `done_flag` pulses for exactly
// one cycle, 17 edges after the start edge, and the results are valid from
// that cycle on. Results and flags hold until the next completion.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous, active-high reset
//   start        in   1   begin an operation (ignored unless IDLE)
//   dividend     in  16   signed dividend, sampled on the start edge
//   divisor      in   8   signed divisor, sampled on the start edge
//   quotient     out  8   signed quotient (registered)
//   remainder    out  8   signed remainder, sign follows the dividend
//   overflow     out  1   true quotient lies outside -128..127
//   div_by_zero  out  1   divisor was zero
//   done_flag    out  1   one-cycle completion pulse
//
// Configuration macro:
//   DIV_SATURATE_EN  defined   -> on overflow the quotient saturates to
//                                 8'h7F (positive) or 8'h80 (negative)
//                    undefined -> on overflow the quotient is the low byte of
//                                 the true signed quotient (wraps)
// -----------------------------------------------------------------------------
module signed_seq_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        overflow,
    output logic        div_by_zero,
    output logic        done_flag
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Two's-complement magnitude of a 16-bit value; -32768 maps to 16'h8000.
    function automatic logic [15:0] abs16(input logic [15:0] v);
        logic [15:0] r;
        if (v[15]) begin
            r = ~v + 16'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement magnitude of an 8-bit value; -128 maps to 8'h80.
    function automatic logic [7:0] abs8(input logic [7:0] v);
        logic [7:0] r;
        if (v[7]) begin
            r = ~v + 8'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Conditionally negate an 8-bit value.
    function automatic logic [7:0] cneg8(input logic [7:0] v, input logic neg);
        logic [7:0] r;
        if (neg) begin
            r = ~v + 8'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic        sd_q,        sd_d;        // dividend sign
    logic        sv_q,        sv_d;        // divisor sign
    logic [15:0] shreg_q,     shreg_d;     // dividend magnitude -> quotient magnitude
    logic [7:0]  dvs_q,       dvs_d;       // divisor magnitude
    // Partial remainder. Only the trial value needs a 9th bit: after every
    // step R < |divisor| <= 128, so the stored remainder fits in 8 bits.
    logic [7:0]  rem_q,       rem_d;
    logic [4:0]  count_q,     count_d;
    logic [7:0]  div_lo_q,    div_lo_d;    // raw dividend low byte for /0 result

    logic [7:0]  quotient_q,  quotient_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        overflow_q,  overflow_d;
    logic        dbz_q,       dbz_d;
    logic        done_q,      done_d;

    // Combinational temporaries
    logic [8:0]  trial_s;      // T = {R[7:0], shift-register MSB}
    logic [15:0] shifted_s;
    logic        q_neg_s;
    logic        ovf_s;
    logic [7:0]  q_low_s;

    // State and datapath register bank with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sd_q        <= 1'b0;
            sv_q        <= 1'b0;
            shreg_q     <= 16'd0;
            dvs_q       <= 8'd0;
            rem_q       <= 8'd0;
            count_q     <= 5'd0;
            div_lo_q    <= 8'd0;
            quotient_q  <= 8'd0;
            remainder_q <= 8'd0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sd_q        <= sd_d;
            sv_q        <= sv_d;
            shreg_q     <= shreg_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            count_q     <= count_d;
            div_lo_q    <= div_lo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            overflow_q  <= overflow_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    // Next-state, datapath and result logic; every target defaults to hold.
    always_comb begin
        state_d     = state_q;
        sd_d        = sd_q;
        sv_d        = sv_q;
        shreg_d     = shreg_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        count_d     = count_q;
        div_lo_d    = div_lo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        overflow_d  = overflow_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        trial_s     = {rem_q, shreg_q[15]};
        shifted_s   = {shreg_q[14:0], 1'b0};
        q_neg_s     = sd_q ^ sv_q;
        // Negative results may reach -128, positive ones only +127.
        if (q_neg_s) begin
            ovf_s = (shreg_q > 16'd128);
        end else begin
            ovf_s = (shreg_q > 16'd127);
        end
        // Low byte of the negated quotient equals the negated low byte.
        q_low_s     = cneg8(shreg_q[7:0], q_neg_s);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sd_d     = dividend[15];
                    sv_d     = divisor[7];
                    shreg_d  = abs16(dividend);
                    dvs_d    = abs8(divisor);
                    rem_d    = 8'd0;
                    count_d  = 5'd16;
                    div_lo_d = dividend[7:0];
                    state_d  = S_CALC;
                end else begin
                    state_d  = S_IDLE;
                end
            end

            S_CALC: begin
                // One restoring step: shift in the next dividend bit and
                // subtract the divisor if it fits.
                if (trial_s >= {1'b0, dvs_q}) begin
                    rem_d   = 8'(trial_s - {1'b0, dvs_q});
                    shreg_d = shifted_s | 16'd1;
                end else begin
                    rem_d   = trial_s[7:0];
                    shreg_d = shifted_s;
                end
                count_d = count_q - 5'd1;
                if (count_q == 5'd1) begin
                    state_d = S_FIXUP;
                end else begin
                    state_d = S_CALC;
                end
            end

            S_FIXUP: begin
                if (dvs_q == 8'd0) begin
                    // The iterations ran only to keep latency fixed; their
                    // result is meaningless for a zero divisor.
                    quotient_d  = 8'h00;
                    remainder_d = div_lo_q;
                    overflow_d  = 1'b0;
                    dbz_d       = 1'b1;
                end else begin
`ifdef DIV_SATURATE_EN
                    if (ovf_s) begin
                        if (q_neg_s) begin
                            quotient_d = 8'h80;
                        end else begin
                            quotient_d = 8'h7F;
                        end
                    end else begin
                        quotient_d = q_low_s;
                    end
`else
                    quotient_d  = q_low_s;
`endif
                    // Truncating division: remainder takes the dividend sign.
                    remainder_d = cneg8(rem_q, sd_q);
                    overflow_d  = ovf_s;
                    dbz_d       = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;
    assign done_flag   = done_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for signed_seq_divider. Expected values are
// hand-computed constants; overflow quotients depend on DIV_SATURATE_EN.
// -----------------------------------------------------------------------------
module tb_signed_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        overflow;
    logic        div_by_zero;
    logic        done_flag;

    int total;
    int bad;

    signed_seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .done_flag   (done_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one operation, measure latency, check results and pulse width.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic eov, input logic edz);
        int lat;
        bit seen;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'hA5A5;
        divisor  = 8'h5A;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_flag) seen = 1'b1;
        end
        check({tag, " latency"}, 16'(lat), 16'd17);
        check({tag, " quotient"}, {8'h00, quotient}, {8'h00, eq});
        check({tag, " remainder"}, {8'h00, remainder}, {8'h00, er});
        check({tag, " overflow"}, {15'd0, overflow}, {15'd0, eov});
        check({tag, " div_by_zero"}, {15'd0, div_by_zero}, {15'd0, edz});
        @(posedge clk);
        #1;
        check({tag, " done width"}, {15'd0, done_flag}, 16'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        int first_lat;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {quotient, remainder}, 16'h0000);
        check("reset flags", {13'd0, overflow, div_by_zero, done_flag}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("15/3",      16'd15,   8'd3,   8'h05, 8'h00, 1'b0, 1'b0);
        run_op("-15/4",     16'hFFF1, 8'd4,   8'hFD, 8'hFD, 1'b0, 1'b0);
        run_op("100/-7",    16'd100,  8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0);
`ifdef DIV_SATURATE_EN
        run_op("1000/3",    16'd1000, 8'd3,   8'h7F, 8'h01, 1'b1, 1'b0);
        run_op("-128/-1",   16'hFF80, 8'hFF,  8'h7F, 8'h00, 1'b1, 1'b0);
`else
        run_op("1000/3",    16'd1000, 8'd3,   8'h4D, 8'h01, 1'b1, 1'b0);
        run_op("-128/-1",   16'hFF80, 8'hFF,  8'h80, 8'h00, 1'b1, 1'b0);
`endif
        run_op("-128/1",    16'hFF80, 8'd1,   8'h80, 8'h00, 1'b0, 1'b0);
        run_op("50/0",      16'd50,   8'd0,   8'h00, 8'h32, 1'b0, 1'b1);
`ifdef DIV_SATURATE_EN
        run_op("-1000/7",   16'hFC18, 8'd7,   8'h80, 8'hFA, 1'b1, 1'b0);
        run_op("-32768/-128", 16'h8000, 8'h80, 8'h7F, 8'h00, 1'b1, 1'b0);
`else
        run_op("-1000/7",   16'hFC18, 8'd7,   8'h72, 8'hFA, 1'b1, 1'b0);
        run_op("-32768/-128", 16'h8000, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0);
`endif
        run_op("-1024/8",   16'hFC00, 8'd8,   8'h80, 8'h00, 1'b0, 1'b0);
        run_op("-7/0",      16'hFFF9, 8'd0,   8'h00, 8'hF9, 1'b0, 1'b1);

        // Back-to-back: start held high, second op accepted as done clears.
        @(negedge clk);
        dividend = 16'd15;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        for (int i = 0; i < 40 && !done_flag; i++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b first latency", 16'(lat), 16'd17);
        check("b2b first quotient", {8'h00, quotient}, 16'h0005);
        dividend = 16'hFFF1;
        divisor  = 8'd4;
        @(posedge clk);
        #1;
        check("b2b done cleared", {15'd0, done_flag}, 16'd0);
        start    = 1'b0;
        dividend = 16'h1234;
        divisor  = 8'h11;
        lat = 0;
        for (int i = 0; i < 40 && !done_flag; i++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b second latency", 16'(lat), 16'd17);
        check("b2b second quotient", {8'h00, quotient}, 16'h00FD);
        check("b2b second remainder", {8'h00, remainder}, 16'h00FD);

        // A start pulse during CALC must be ignored.
        @(negedge clk);
        dividend = 16'd15;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        ndone     = 0;
        first_lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) begin
                start    = 1'b1;
                dividend = 16'd100;
                divisor  = 8'hF9;
            end
            if (i == 5) start = 1'b0;
            if (done_flag) begin
                ndone++;
                if (ndone == 1) first_lat = i;
            end
        end
        check("ignore start pulses", 16'(ndone), 16'd1);
        check("ignore start latency", 16'(first_lat), 16'd17);
        check("ignore start quotient", {8'h00, quotient}, 16'h0005);
        check("ignore start remainder", {8'h00, remainder}, 16'h0000);

        // Make the outputs nonzero, then reset in the middle of the next op.
        run_op("pre-reset -1000/7", 16'hFC18, 8'd7,
`ifdef DIV_SATURATE_EN
               8'h80,
`else
               8'h72,
`endif
               8'hFA, 1'b1, 1'b0);
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid reset outputs", {quotient, remainder}, 16'h0000);
        check("mid reset flags", {13'd0, overflow, div_by_zero, done_flag}, 16'd0);
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done_flag) ndone++;
        end
        check("no done after reset", 16'(ndone), 16'd0);
        check("outputs stay cleared", {quotient, remainder}, 16'h0000);

`ifdef DIV_SATURATE_EN
        run_op("32767/127", 16'h7FFF, 8'd127, 8'h7F, 8'h01, 1'b1, 1'b0);
`else
        run_op("32767/127", 16'h7FFF, 8'd127, 8'h02, 8'h01, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/signed_seq_divider.md
# signed_seq_divider

Sequential signed 16-by-8 integer divider, the inverse of the team's 8x8 signed sequential multiplier: it takes a 16-bit signed dividend and an 8-bit signed divisor and returns an 8-bit signed quotient and remainder. It uses the same `start` / `done_flag` handshake as the multiplier, so a top-level wrapper can drive either unit and show results on the Nexys 4 DDR seven-segment display. The datapath is restoring division on magnitudes, followed by a sign fix-up stage.

## Interface
Parameters: none. Widths are fixed.

Ports:
- `clk`  input  1  Rising-edge clock.
- `rst`  input  1  Asynchronous, active-high reset.
- `start`  input  1  Starts an operation. Sampled only in IDLE.
- `dividend`  input  16  Signed dividend. Sampled on the start edge.
- `divisor`  input  8  Signed divisor. Sampled on the start edge.
- `quotient`  output  8  Signed quotient, registered.
- `remainder`  output  8  Signed remainder, registered.
- `overflow`  output  1  True quotient is outside -128..127.
- `div_by_zero`  output  1  Divisor was 0.
- `done_flag`  output  1  One-cycle completion pulse.

## Operation
- States:
  - IDLE: wait for `start`.
  - CALC: 16 iterations.
  - FIXUP: apply signs, check flags, write outputs.
- IDLE, when `start`=1:
  - Latch `sd`=`dividend[15]` and `sv`=`divisor[7]`.
  - Latch magnitudes: 16-bit unsigned `|dividend|` (−32768 → 16'h8000) into the quotient shift register, and 8-bit unsigned `|divisor|` (−128 → 8'h80).
  - Clear the 9-bit partial remainder `R`; set `count`=16.
  - `done_flag`=0 in IDLE.
- CALC, each cycle:
  - `T` = {`R`[7:0], shift-register MSB}.
  - Shift the shift register left by 1.
  - If `T` ≥ `|divisor|`: `R` = `T` − `|divisor|` and the new LSB = 1. Otherwise `R` = `T` and the new LSB = 0.
  - Decrement `count`. When `count`==1, go to FIXUP.
- FIXUP, single cycle:
  - `Qm` = 16-bit magnitude quotient; `Rm` = `R`[7:0].
  - Quotient sign = `sd` ^ `sv`. Remainder sign = `sd` (truncating division).
  - `overflow` = (`Qm` > 127 when the sign is positive) or (`Qm` > 128 when the sign is negative).
  - `quotient` = low 8 bits of the signed quotient, or the saturated value (see Configuration).
  - `remainder` = ±`Rm`. It always fits in 8 bits because |rem| < |divisor| ≤ 128.
  - `done_flag`=1, then return to IDLE.
- Divisor == 0: the operation still runs the full fixed latency.
  - Results: `div_by_zero`=1, `quotient`=8'h00, `remainder`=`dividend[7:0]`, `overflow`=0.
- Output holding and flags:
  - `quotient`, `remainder`, `overflow` and `div_by_zero` hold their values until the next FIXUP.
  - Both flags are rewritten on every completion.
- `start` while in CALC or FIXUP is ignored; there is no queueing.
- `dividend` and `divisor` may change freely after the start edge.

## Timing
- Reset values: every output 0; state IDLE; all internal registers 0.
- Latency, with `start` sampled at edge N:
  - Edges N+1 to N+16: CALC.
  - Edge N+17: FIXUP writes outputs and asserts `done_flag`.
  - Edge N+18: `done_flag` clears.
- `done_flag` is high for exactly one cycle. Results are valid in that same cycle.
- Earliest next start is the edge N+18 (back-to-back ops: start held high ⇒ new op accepted at the edge `done_flag` clears, throughput one per 18 cycles).
- Reset mid-operation: everything clears immediately. No `done_flag` is produced and no partial result becomes visible.
- Reset asserted on the same edge as `start`: reset wins.

## Configuration
- Macro `DIV_SATURATE_EN`.
- Defined: when `overflow`=1, `quotient` saturates to 8'h7F (positive result) or 8'h80 (negative result).
- Undefined: when `overflow`=1, `quotient` = low 8 bits of the true signed quotient (wraps).
- In both builds, the `overflow` flag, `remainder` and latency are identical.

## Test plan
- 15 / 3 → `quotient`=8'h05, `remainder`=8'h00, both flags 0; `done_flag` 17 edges after the start edge, for one cycle.
- −15 / 4 → `quotient`=8'hFD (−3), `remainder`=8'hFD (−3). 100 / −7 → `quotient`=8'hF2 (−14), `remainder`=8'h02.
- 1000 / 3 → `overflow`=1, `remainder`=8'h01.
  - With `DIV_SATURATE_EN`: `quotient`=8'h7F.
  - Without it: `quotient`=8'h4D (333 mod 256).
- −128 / −1 → `overflow`=1, `quotient`=8'h7F (saturated build). −128 / 1 → `quotient`=8'h80, `overflow`=0.
- 50 / 0 → `div_by_zero`=1, `quotient`=8'h00, `remainder`=8'h32, `overflow`=0, same latency as a normal operation.
- Reset at edge N+8 of an operation → all outputs 0 and no `done_flag` pulse. `start` pulsed at N+5 (during CALC) is ignored: exactly one `done_flag` at N+17, with the first operation's result.
